mmio_parallel_port: RTL

//  Parametrised memory-mapped parallel I/O for the single-cycle CPU. Replaces the fixed one-input/one-output split.

---
 rtl/mmio_pkg.sv | 23 ++
 rtl/mmio_input_conditioner.sv | 90 +++++++++
 rtl/mmio_parallel_port.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared constants and helpers for the memory-mapped parallel port
//
// Purpose: default window bases, window span, index-width helper and the
//          debounce-build flag used by the port and its input conditioners.
// Ports:   none (package).
// Config:  MMIO_DEBOUNCE_EN selects the debounced input path.
package mmio_pkg;

  // Every I/O window spans eight addresses, the maximum channel count.
  localparam int WIN_SPAN = 8;

  localparam logic [7:0] DEF_OUT_BASE  = 8'hF0;
  localparam logic [7:0] DEF_IN_BASE   = 8'hE0;
  localparam logic [7:0] DEF_EDGE_BASE = 8'hE8;

  // Width needed to index n items; never less than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WIN_IDX_W = ch_idx_w(WIN_SPAN);

endpackage

// File: rtl/mmio_input_conditioner.sv
// rtl/mmio_input_conditioner.sv - one input channel: sync, optional debounce, edge flags
//
// Purpose: 2-flop synchroniser, optional debounce filter, per-bit rising-edge
//          sticky flags with write-1-to-clear.
// Ports:   clk, rst   clock, async active-high reset
//          pin        asynchronous input pins of this channel
//          clr        W1C mask (already qualified by the store decode)
//          filt       conditioned input value
//          flag       sticky rising-edge flags
// Config:  MMIO_DEBOUNCE_EN adds the per-channel stability counter.
module mmio_input_conditioner
  import mmio_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pin,
  input  logic [DATA_W-1:0] clr,
  output logic [DATA_W-1:0] filt,
  output logic [DATA_W-1:0] flag
);

  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] s2;
  logic [DATA_W-1:0] filt_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int CNT_W = ch_idx_w(DB_CYCLES);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] cand;

  // cand trails s2 by one cycle; cnt counts consecutive cycles of agreement.
  // filt is loaded on the step that brings cnt to DB_CYCLES-1, then the
  // counter saturates until s2 moves again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= '0;
      cnt  <= '0;
      filt <= '0;
    end else begin
      cand <= s2;
      if (s2 != cand) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(DB_CYCLES - 1)) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(DB_CYCLES - 2)) begin
          filt <= cand;
        end
      end
    end
  end
`else
  // DB_CYCLES only matters when the debounce filter is built in.
  logic [31:0] db_cycles_unused;
  assign db_cycles_unused = 32'(DB_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= '0;
    end else begin
      filt <= s2;
    end
  end
`endif

  // A new rising edge takes precedence over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_prev <= '0;
      flag      <= '0;
    end else begin
      filt_prev <= filt;
      flag      <= (flag & ~clr) | (filt & ~filt_prev);
    end
  end

endmodule

// File: rtl/mmio_parallel_port.sv
// rtl/mmio_parallel_port.sv - memory-mapped parallel I/O between CPU datapath and data RAM
//
// Purpose: NUM_OUT output registers, NUM_IN conditioned inputs with edge flags
//          and an IRQ line; all other addresses pass through to data RAM.
// Ports:   clk, rst   clock, async active-high reset
//          addr       byte address            we        store strobe
//          wr_data    store data              mem_rdata data RAM read data
//          rd_data    load data               mem_wren  data RAM write enable
//          pin_in     input pins, channel i at [i*DATA_W +: DATA_W]
//          pin_out    output registers, same packing
//          edge_irq   OR of all edge flags
// Config:  MMIO_DEBOUNCE_EN enables input debouncing (DB_CYCLES window).
module mmio_parallel_port
  import mmio_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                NUM_OUT   = 2,
  parameter int                NUM_IN    = 2,
  parameter logic [ADDR_W-1:0] OUT_BASE  = ADDR_W'(DEF_OUT_BASE),
  parameter logic [ADDR_W-1:0] IN_BASE   = ADDR_W'(DEF_IN_BASE),
  parameter logic [ADDR_W-1:0] EDGE_BASE = ADDR_W'(DEF_EDGE_BASE),
  parameter int                DB_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      we,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      mem_wren,
  input  logic [NUM_IN*DATA_W-1:0]  pin_in,
  output logic [NUM_OUT*DATA_W-1:0] pin_out,
  output logic                      edge_irq
);

  // Window decode: offset from each base, in-window when offset < WIN_SPAN.
  logic [ADDR_W-1:0]    off_out, off_in, off_edge;
  logic                 in_out_win, in_in_win, in_edge_win;
  logic                 hit_out, hit_in, hit_edge, io_hit;
  logic [WIN_IDX_W-1:0] idx_out, idx_in, idx_edge;

  assign off_out  = addr - OUT_BASE;
  assign off_in   = addr - IN_BASE;
  assign off_edge = addr - EDGE_BASE;

  assign in_out_win  = off_out  < ADDR_W'(WIN_SPAN);
  assign in_in_win   = off_in   < ADDR_W'(WIN_SPAN);
  assign in_edge_win = off_edge < ADDR_W'(WIN_SPAN);

  assign idx_out  = off_out[WIN_IDX_W-1:0];
  assign idx_in   = off_in[WIN_IDX_W-1:0];
  assign idx_edge = off_edge[WIN_IDX_W-1:0];

  // Priority out > in > edge only matters for a misconfigured overlap.
  assign hit_out  = in_out_win;
  assign hit_in   = ~in_out_win & in_in_win;
  assign hit_edge = ~in_out_win & ~in_in_win & in_edge_win;
  assign io_hit   = hit_out | hit_in | hit_edge;

  assign mem_wren = we & ~io_hit;

  // Output registers.
  logic [DATA_W-1:0] out_q [NUM_OUT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        out_q[i] <= '0;
      end
    end else if (we && hit_out) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (idx_out == WIN_IDX_W'(i)) begin
          out_q[i] <= wr_data;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    assign pin_out[i*DATA_W +: DATA_W] = out_q[i];
  end

  // Input channels.
  logic [DATA_W-1:0] filt [NUM_IN];
  logic [DATA_W-1:0] flag [NUM_IN];

  for (genvar c = 0; c < NUM_IN; c++) begin : g_in
    logic [DATA_W-1:0] clr;

    assign clr = (we && hit_edge && idx_edge == WIN_IDX_W'(c)) ? wr_data : '0;

    mmio_input_conditioner #(
      .DATA_W    (DATA_W),
      .DB_CYCLES (DB_CYCLES)
    ) u_cond (
      .clk  (clk),
      .rst  (rst),
      .pin  (pin_in[c*DATA_W +: DATA_W]),
      .clr  (clr),
      .filt (filt[c]),
      .flag (flag[c])
    );
  end

  always_comb begin
    edge_irq = 1'b0;
    for (int c = 0; c < NUM_IN; c++) begin
      edge_irq = edge_irq | (|flag[c]);
    end
  end

  // Load mux; unpopulated slots inside a window read zero.
  always_comb begin
    rd_data = mem_rdata;
    if (hit_out) begin
      rd_data = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        if (idx_out == WIN_IDX_W'(i)) rd_data = out_q[i];
      end
    end else if (hit_in) begin
      rd_data = '0;
      for (int c = 0; c < NUM_IN; c++) begin
        if (idx_in == WIN_IDX_W'(c)) rd_data = filt[c];
      end
    end else if (hit_edge) begin
      rd_data = '0;
      for (int c = 0; c < NUM_IN; c++) begin
        if (idx_edge == WIN_IDX_W'(c)) rd_data = flag[c];
      end
    end
  end

endmodule
